// File: rtl/elevator_scheduler.sv
// Single-car elevator scheduler: collective up/down control over car and hall calls,
// issuing one-cycle clear pulses to the button block as each request is served.
module elevator_scheduler #(
   parameter int FLOORS        = 8,
   parameter int TRAVEL_CYCLES = 16,
   parameter int DOOR_CYCLES   = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [FLOORS-1:0] active_in_levels,
   input  logic [FLOORS-1:0] active_out_up_levels,
   input  logic [FLOORS-1:0] active_out_down_levels,
   input  logic              door_hold,
   output logic [FLOORS-1:0] inactivate_in_levels,
   output logic [FLOORS-1:0] inactivate_out_up_levels,
   output logic [FLOORS-1:0] inactivate_out_down_levels,
   output logic [3:0]        buttons_blocked,
   output logic [3:0]        current_floor,
   output logic [1:0]        direction,
   output logic              door_open,
   output logic              moving,
   output logic [1:0]        state_dbg
);
   localparam int TW = $clog2(TRAVEL_CYCLES);
   localparam int DW = $clog2(DOOR_CYCLES);
   localparam logic [TW-1:0] T_LOAD = TW'(TRAVEL_CYCLES - 1);
   localparam logic [DW-1:0] D_LOAD = DW'(DOOR_CYCLES - 1);
   localparam logic [1:0] DIR_IDLE = 2'b00;
   localparam logic [1:0] DIR_UP   = 2'b01;
   localparam logic [1:0] DIR_DOWN = 2'b10;

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_MOVE = 2'd1, S_DOOR = 2'd2} state_t;

   state_t            state, state_n;
   logic [3:0]        floor_n, next_floor;
   logic [1:0]        dir_n;
   logic              pref_up, pref_up_n;
   logic [TW-1:0]     tcnt, tcnt_n;
   logic [DW-1:0]     dcnt, dcnt_n;
   logic [FLOORS-1:0] clr_in_n, clr_up_n, clr_dn_n;
   logic [FLOORS-1:0] req, cf_mask, cf_hi, cf_lo, nf_mask, nf_hi, nf_lo;
   logic [FLOORS-1:0] new_in, new_up, new_dn;
   logic              above, below, going_up, ahead, behind, stop_here;

   assign req        = active_in_levels | active_out_up_levels | active_out_down_levels;
   assign next_floor = (direction == DIR_DOWN) ? current_floor - 4'd1 : current_floor + 4'd1;
   assign state_dbg  = state;

   // Floor masks relative to the current floor and to the floor being arrived at.
   always_comb begin
      cf_mask = '0;
      cf_hi   = '0;
      cf_lo   = '0;
      nf_mask = '0;
      nf_hi   = '0;
      nf_lo   = '0;
      for (int i = 0; i < FLOORS; i++) begin
         cf_mask[i] = (i == int'(current_floor));
         cf_hi[i]   = (i >  int'(current_floor));
         cf_lo[i]   = (i <  int'(current_floor));
         nf_mask[i] = (i == int'(next_floor));
         nf_hi[i]   = (i >  int'(next_floor));
         nf_lo[i]   = (i <  int'(next_floor));
      end
   end

   assign above = |(req & cf_hi);
   assign below = |(req & cf_lo);

   always_comb begin
      state_n   = state;
      floor_n   = current_floor;
      dir_n     = direction;
      pref_up_n = pref_up;
      tcnt_n    = tcnt;
      dcnt_n    = dcnt;
      clr_in_n  = '0;
      clr_up_n  = '0;
      clr_dn_n  = '0;
      new_in    = '0;
      new_up    = '0;
      new_dn    = '0;
      going_up  = (direction != DIR_DOWN);
      ahead     = going_up ? |(req & nf_hi) : |(req & nf_lo);
      behind    = going_up ? |(req & nf_lo) : |(req & nf_hi);
      stop_here = 1'b0;
      case (state)
         S_IDLE: begin
            dir_n = DIR_IDLE;
            if (|(req & cf_mask)) begin
               state_n  = S_DOOR;
               dcnt_n   = D_LOAD;
               clr_in_n = active_in_levels & cf_mask;
               clr_up_n = active_out_up_levels & cf_mask;
               clr_dn_n = active_out_down_levels & cf_mask;
            end else if (above && (pref_up || !below)) begin
               state_n   = S_MOVE;
               dir_n     = DIR_UP;
               pref_up_n = 1'b1;
               tcnt_n    = T_LOAD;
            end else if (below) begin
               state_n   = S_MOVE;
               dir_n     = DIR_DOWN;
               pref_up_n = 1'b0;
               tcnt_n    = T_LOAD;
            end
         end
         S_MOVE: begin
            if (tcnt != '0) begin
               tcnt_n = tcnt - TW'(1);
            end else begin
               tcnt_n    = T_LOAD;
               floor_n   = next_floor;
               // An empty run ahead also covers the end floors, so the car can never overshoot.
               stop_here = |(active_in_levels & nf_mask) | !ahead |
                           (going_up ? |(active_out_up_levels & nf_mask)
                                     : |(active_out_down_levels & nf_mask));
               if (stop_here) begin
                  state_n  = S_DOOR;
                  dcnt_n   = D_LOAD;
                  clr_in_n = active_in_levels & nf_mask;
                  if (going_up || !ahead)  clr_up_n = active_out_up_levels & nf_mask;
                  if (!going_up || !ahead) clr_dn_n = active_out_down_levels & nf_mask;
                  if (!ahead) begin
                     if (behind) begin
                        dir_n     = going_up ? DIR_DOWN : DIR_UP;
                        pref_up_n = !going_up;
                     end else begin
                        dir_n = DIR_IDLE;
                     end
                  end
               end
            end
         end
         S_DOOR: begin
            // Masking by the outputs ignores a request whose clear is already on the wire.
            new_in = active_in_levels & cf_mask & ~inactivate_in_levels;
            new_up = (direction != DIR_DOWN) ?
                     (active_out_up_levels & cf_mask & ~inactivate_out_up_levels) : '0;
            new_dn = (direction != DIR_UP) ?
                     (active_out_down_levels & cf_mask & ~inactivate_out_down_levels) : '0;
            if (|(new_in | new_up | new_dn)) begin
               clr_in_n = new_in;
               clr_up_n = new_up;
               clr_dn_n = new_dn;
               dcnt_n   = D_LOAD;
            end else if (door_hold) begin
               dcnt_n = D_LOAD;
            end else if (dcnt != '0) begin
               dcnt_n = dcnt - DW'(1);
            end else begin
               state_n = S_IDLE;
               dir_n   = DIR_IDLE;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state                      <= S_IDLE;
         current_floor              <= '0;
         direction                  <= DIR_IDLE;
         pref_up                    <= 1'b1;
         tcnt                       <= '0;
         dcnt                       <= '0;
         inactivate_in_levels       <= '0;
         inactivate_out_up_levels   <= '0;
         inactivate_out_down_levels <= '0;
         buttons_blocked            <= 4'hF;
         door_open                  <= 1'b0;
         moving                     <= 1'b0;
      end else begin
         state                      <= state_n;
         current_floor              <= floor_n;
         direction                  <= dir_n;
         pref_up                    <= pref_up_n;
         tcnt                       <= tcnt_n;
         dcnt                       <= dcnt_n;
         inactivate_in_levels       <= clr_in_n;
         inactivate_out_up_levels   <= clr_up_n;
         inactivate_out_down_levels <= clr_dn_n;
         buttons_blocked            <= (state_n == S_DOOR) ? floor_n : 4'hF;
         door_open                  <= (state_n == S_DOOR);
         moving                     <= (state_n == S_MOVE);
      end
   end
endmodule

// File: tb/tb_elevator_scheduler.sv
// Directed bench for elevator_scheduler: a button-block model latches presses and
// drops them on clear pulses; every observed pulse is matched against an expected queue.
module tb_elevator_scheduler;
   localparam int FLOORS = 8;
   localparam int T      = 4;
   localparam int D      = 8;
   localparam int W      = 6;
   localparam int K_IN   = 1;
   localparam int K_UP   = 2;
   localparam int K_DN   = 3;

   logic              clk = 1'b0;
   logic              reset;
   logic              door_hold;
   logic [FLOORS-1:0] btn_in, btn_up, btn_dn;
   logic [FLOORS-1:0] set_in, set_up, set_dn;
   logic [FLOORS-1:0] clr_in, clr_up, clr_dn;
   logic [3:0]        buttons_blocked, current_floor;
   logic [1:0]        direction, state_dbg;
   logic              door_open, moving;

   int checks = 0;
   int passes = 0;
   logic [W-1:0] exp_q[$];

   // clock / reset
   always #5 clk = ~clk;

   elevator_scheduler #(.FLOORS(FLOORS), .TRAVEL_CYCLES(T), .DOOR_CYCLES(D)) dut (
      .clk                        (clk),
      .reset                      (reset),
      .active_in_levels           (btn_in),
      .active_out_up_levels       (btn_up),
      .active_out_down_levels     (btn_dn),
      .door_hold                  (door_hold),
      .inactivate_in_levels       (clr_in),
      .inactivate_out_up_levels   (clr_up),
      .inactivate_out_down_levels (clr_dn),
      .buttons_blocked            (buttons_blocked),
      .current_floor              (current_floor),
      .direction                  (direction),
      .door_open                  (door_open),
      .moving                     (moving),
      .state_dbg                  (state_dbg)
   );

   // button block model
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         btn_in <= '0;
         btn_up <= '0;
         btn_dn <= '0;
      end else begin
         btn_in <= (btn_in & ~clr_in) | set_in;
         btn_up <= (btn_up & ~clr_up) | set_up;
         btn_dn <= (btn_dn & ~clr_dn) | set_dn;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // scoreboard: each set clear bit is one event {kind, floor}, in-up-down then floor order
   always @(negedge clk) begin
      logic [FLOORS-1:0] v;
      logic [W-1:0]      code, want;
      for (int k = K_IN; k <= K_DN; k++) begin
         v = (k == K_IN) ? clr_in : (k == K_UP) ? clr_up : clr_dn;
         for (int f = 0; f < FLOORS; f++) begin
            if (v[f]) begin
               code = {2'(k), 4'(f)};
               want = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
               check("clear_pulse", 32'(code), 32'(want));
            end
         end
      end
   end

   // driver tasks
   task automatic expect_pulse(input int kind, input int f);
      exp_q.push_back({2'(kind), 4'(f)});
   endtask

   task automatic press(input int kind, input int f);
      @(negedge clk);
      if (kind == K_IN)      set_in = FLOORS'(1) << f;
      else if (kind == K_UP) set_up = FLOORS'(1) << f;
      else                   set_dn = FLOORS'(1) << f;
      @(negedge clk);
      set_in = '0;
      set_up = '0;
      set_dn = '0;
   endtask

   task automatic wait_moving(input int budget, output int cycles);
      cycles = 0;
      while (!moving && cycles < budget) begin
         @(negedge clk);
         cycles++;
      end
   endtask

   task automatic wait_door(input int budget, output int cycles);
      cycles = 0;
      while (!door_open && cycles < budget) begin
         @(negedge clk);
         cycles++;
      end
   endtask

   task automatic wait_closed(input int budget, output int cycles);
      cycles = 0;
      while (door_open && cycles < budget) begin
         @(negedge clk);
         cycles++;
      end
   endtask

   task automatic serve_car_call(input int f);
      int c;
      expect_pulse(K_IN, f);
      press(K_IN, f);
      wait_moving(8, c);
      check("reposition_start", 32'(moving), 1);
      wait_door(FLOORS * T + 8, c);
      check("reposition_floor", 32'(current_floor), 32'(f));
      wait_closed(D + 4, c);
      check("reposition_close", 32'(c), D);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int c;
      int held;
      reset     = 1'b0;
      door_hold = 1'b0;
      set_in    = '0;
      set_up    = '0;
      set_dn    = '0;
      repeat (3) @(negedge clk);
      check("rst_floor", 32'(current_floor), 0);
      check("rst_dir", 32'(direction), 0);
      check("rst_door", 32'(door_open), 0);
      check("rst_moving", 32'(moving), 0);
      check("rst_blocked", 32'(buttons_blocked), 32'hF);
      check("rst_clears", 32'({clr_in, clr_up, clr_dn}), 0);
      check("rst_state", 32'(state_dbg), 0);
      reset = 1'b1;

      // hall up-call at the idle floor: door opens next cycle, no travel
      expect_pulse(K_UP, 0);
      press(K_UP, 0);
      @(negedge clk);
      check("a_door", 32'(door_open), 1);
      check("a_moving", 32'(moving), 0);
      check("a_floor", 32'(current_floor), 0);
      check("a_blocked", 32'(buttons_blocked), 0);
      check("a_dir", 32'(direction), 0);
      wait_closed(D + 4, c);
      check("a_door_len", 32'(c), D);
      check("a_still", 32'(moving), 0);

      // car call to 5: five floors of travel then door
      expect_pulse(K_IN, 5);
      press(K_IN, 5);
      wait_moving(8, c);
      check("b_start_latency", 32'(c), 1);
      check("b_dir_up", 32'(direction), 1);
      wait_door(5 * T + 8, c);
      check("b_travel", 32'(c), 5 * T);
      check("b_floor", 32'(current_floor), 5);
      check("b_blocked", 32'(buttons_blocked), 5);
      check("b_dir_done", 32'(direction), 0);
      check("b_moving", 32'(moving), 0);
      wait_closed(D + 4, c);
      check("b_door_len", 32'(c), D);
      check("b_blocked_free", 32'(buttons_blocked), 32'hF);

      serve_car_call(0);

      // up-call at 3 made while below it: intermediate stop, then on to 6
      expect_pulse(K_UP, 3);
      expect_pulse(K_IN, 6);
      press(K_IN, 6);
      wait_moving(8, c);
      check("c1_dir", 32'(direction), 1);
      press(K_UP, 3);
      wait_door(6 * T + 8, c);
      check("c1_stop_floor", 32'(current_floor), 3);
      check("c1_stop_dir", 32'(direction), 1);
      wait_closed(D + 4, c);
      wait_moving(8, c);
      check("c1_resume", 32'(moving), 1);
      wait_door(6 * T + 8, c);
      check("c1_final_floor", 32'(current_floor), 6);
      check("c1_final_dir", 32'(direction), 0);
      wait_closed(D + 4, c);

      serve_car_call(0);

      // down-call at 3 is passed going up, served after reversing at 6
      expect_pulse(K_IN, 6);
      expect_pulse(K_DN, 3);
      press(K_IN, 6);
      wait_moving(8, c);
      press(K_DN, 3);
      wait_door(6 * T + 8, c);
      check("c2_passed_to", 32'(current_floor), 6);
      check("c2_reverse", 32'(direction), 2);
      wait_closed(D + 4, c);
      wait_moving(8, c);
      check("c2_dir_down", 32'(direction), 2);
      wait_door(6 * T + 8, c);
      check("c2_down_floor", 32'(current_floor), 3);
      check("c2_down_dir", 32'(direction), 0);
      wait_closed(D + 4, c);

      // door hold at floor 2
      expect_pulse(K_IN, 2);
      press(K_IN, 2);
      wait_moving(8, c);
      wait_door(2 * T + 8, c);
      check("d_floor", 32'(current_floor), 2);
      door_hold = 1'b1;
      held = 0;
      repeat (100) begin
         @(negedge clk);
         if (door_open) held++;
      end
      check("d_hold", 32'(held), 100);
      door_hold = 1'b0;
      wait_closed(D + 4, c);
      check("d_release_len", 32'(c), D);
      check("d_idle", 32'(state_dbg), 0);

      // reset while moving past floor 4
      press(K_IN, 7);
      wait_moving(8, c);
      c = 0;
      while (current_floor != 4'd4 && c < 8 * T) begin
         @(negedge clk);
         c++;
      end
      check("e_reach4", 32'(current_floor), 4);
      @(negedge clk);
      #2 reset = 1'b0;
      #1;
      check("e_rst_floor", 32'(current_floor), 0);
      check("e_rst_moving", 32'(moving), 0);
      check("e_rst_state", 32'(state_dbg), 0);
      check("e_rst_dir", 32'(direction), 0);
      check("e_rst_blocked", 32'(buttons_blocked), 32'hF);
      @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      check("e_after_floor", 32'(current_floor), 0);
      check("e_after_moving", 32'(moving), 0);
      check("e_after_door", 32'(door_open), 0);

      check("scoreboard_drained", 32'(exp_q.size()), 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
